// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Sums a programmed number of signed 16-bit products from the upstream 8x8
// multiplier into a wider signed accumulator. When the final product has been
// added, done pulses for one cycle while acc_out holds the total.
//
// Sequence:
//   IDLE/DONE + start : clear the sum and the overflow flag, load the count.
//                       A count of 0 goes straight to DONE with a zero sum.
//   ACCUM             : add each product qualified by prod_valid. Gaps of any
//                       length are allowed. start is ignored.
//   DONE              : a single cycle. done is high and busy is low. A new
//                       start may be accepted in this cycle.
//
// Optional build macro:
//   MAC_ACCUMULATOR_SAT_EN - on signed overflow, acc_out clamps to the most
//                            positive or most negative value, matching the
//                            sign of the addends. Later products add to the
//                            clamped value and still saturate. When the macro
//                            is undefined, the sum wraps in two's complement.
//                            overflow is flagged in both builds.
//
// Parameters:
//   ACC_W      - accumulator/result width (>= 16); products are sign-extended
//   CNT_W      - width of the product-count field (max 2^CNT_W - 1 products)
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset; aborts any sequence, no done
//   start      - begin a new accumulation (honoured only in IDLE or DONE)
//   count      - number of products to accumulate, sampled with start
//   prod       - signed product from the multiplier
//   prod_valid - prod is valid this cycle (counted only in ACCUM)
//   acc_out    - signed running/final sum, registered
//   busy       - high while accumulating
//   done       - one-cycle pulse; acc_out is final while done is high
//   overflow   - sticky signed-overflow flag for the current sequence
// -----------------------------------------------------------------------------
module mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_d;
    logic [ACC_W-1:0] acc_d;
    logic             overflow_d;

    // Datapath: sign-extend the product, add it, and detect signed overflow.
    // Overflow occurs when both addends have the same sign and the sum's sign
    // differs from them.
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_next;

    assign prod_ext = ACC_W'($signed(prod));
    assign sum      = acc_out + prod_ext;
    assign add_ovf  = (acc_out[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1]     != acc_out[ACC_W-1]);

`ifdef MAC_ACCUMULATOR_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both addends share a sign, so the accumulator's sign picks
    // which rail to clamp to.
    assign acc_next = add_ovf ? (acc_out[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign acc_next = sum;
`endif

    // Next-state and next-value logic.
    // NOTE: every signal is given a default first, so no path through the
    // case statement leaves a signal unassigned. An unassigned path would infer a latch.
    always_comb begin
        state_d     = state;
        acc_d       = acc_out;
        overflow_d  = overflow;
        remaining_d = remaining;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    if (count != '0) begin
                        remaining_d = count;
                        state_d     = ACCUM;
                    end else begin
                        remaining_d = '0;
                        state_d     = DONE;
                    end
                end else if (state == DONE) begin
                    state_d = IDLE;
                end
            end

            ACCUM: begin
                if (prod_valid) begin
                    acc_d       = acc_next;
                    overflow_d  = overflow | add_ovf;
                    remaining_d = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc_out   <= '0;
            overflow  <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_d;
            acc_out   <= acc_d;
            overflow  <= overflow_d;
            remaining <= remaining_d;
        end
    end

    // Status is decoded directly from the state register. There is no
    // combinational path from the inputs to these outputs.
    assign busy = (state == ACCUM);
    assign done = (state == DONE);

endmodule
